// File: rtl/io_memory.sv
// io_memory: memory-mapped I/O block for the MIPS MEM stage.
// Holds a 2^ADDR_W byte big-endian store accessed as aligned 32-bit words,
// with a combinational tri-stated read port. It also contains a one-shot
// 16-bit down-counting timer that raises io_intr until the CPU acknowledges.
// Writing the word at TMR_ADDR reloads the timer; a reload of 0 disarms it.
module io_memory #(
  parameter int                ADDR_W     = 12,
  parameter int                INTR_DELAY = 20,
  parameter logic [ADDR_W-1:0] TMR_ADDR   = 12'hFFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_cs,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       D_In,
  output logic [31:0]       D_Out,
  input  logic              intr_ack,
  output logic              io_intr
);

  localparam int DEPTH = 1 << ADDR_W;

  // Byte store; deliberately never reset so a simulator hex preload survives.
  logic [7:0] M [0:DEPTH-1];

  logic [ADDR_W-1:0] base;
  logic              wr_en;
  logic              rd_en;
  logic              reload;
  logic [7:0]        rd_bytes [4];
  logic [31:0]       rd_word;

  logic [15:0]       cnt_reg;
  logic [15:0]       cnt_next;
  logic              intr_reg;
  logic              intr_next;

  // Word base: the two low address bits are masked off.
  assign base   = Address & ~ADDR_W'(3);
  assign wr_en  = io_cs & io_wr;
  // A write wins over a simultaneous read, so the bus stays released.
  assign rd_en  = io_cs & io_rd & ~io_wr;
  assign reload = wr_en && (base == TMR_ADDR);

  // Byte lane k of the word sits at base+k; lane 0 is the most significant.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_bytes[gi] = M[base | ADDR_W'(gi)];
    end
  endgenerate

  assign rd_word = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
  assign D_Out   = rd_en ? rd_word : {32{1'bz}};
  assign io_intr = intr_reg;

  // Big-endian word write into the byte array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        M[base | ADDR_W'(i)] <= D_In[31-8*i -: 8];
      end
    end
  end

  // Timer next state: reload beats countdown, expiry sets the flag, ack clears it last.
  always_comb begin
    cnt_next  = cnt_reg;
    intr_next = intr_reg;
    if (reload) begin
      cnt_next = D_In[15:0];
    end else if (cnt_reg != 16'd0) begin
      cnt_next = cnt_reg - 16'd1;
    end
    if (!reload && (cnt_reg == 16'd1)) begin
      intr_next = 1'b1;
    end
    if (intr_reg && intr_ack) begin
      intr_next = 1'b0;
    end
  end

  // Timer registers; asynchronous reset re-arms the power-on interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= 16'(INTR_DELAY);
      intr_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      intr_reg <= intr_next;
    end
  end

endmodule

// File: tb/tb_io_memory.sv
// tb_io_memory: directed and randomized checks of io_memory against a
// word-level memory map and an edge-count based interrupt timer model.
module tb_io_memory;

  localparam int ADDR_W     = 12;
  localparam int INTR_DELAY = 20;
  localparam int TMR_WORD   = 'hFFC >> 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              io_cs = 1'b0;
  logic              io_wr = 1'b0;
  logic              io_rd = 1'b0;
  logic              intr_ack = 1'b0;
  logic [ADDR_W-1:0] Address = '0;
  logic [31:0]       D_In = '0;
  wire  [31:0]       D_Out;
  wire               io_intr;

  io_memory #(
    .ADDR_W    (ADDR_W),
    .INTR_DELAY(INTR_DELAY),
    .TMR_ADDR  (12'hFFC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_cs   (io_cs),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .Address (Address),
    .D_In    (D_In),
    .D_Out   (D_Out),
    .intr_ack(intr_ack),
    .io_intr (io_intr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: memory as a map of word index -> word value, timer as
  // "fires on absolute edge number m_due" rather than a running counter.
  logic [31:0] mem_m [int];
  int          m_edge;
  int          m_due;
  bit          m_armed;
  bit          m_intr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_edge  = 0;
    m_due   = INTR_DELAY;
    m_armed = (INTR_DELAY != 0);
    m_intr  = 1'b0;
  endfunction

  // One bus cycle; called between a rising edge and the following falling edge.
  task automatic cycle(input bit cs, input bit wr, input bit rd,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] din,
                       input bit ack);
    int          w;
    bit          reload;
    bit          fire;
    bit          nxt;
    logic [31:0] dout_s;
    io_cs    = cs;
    io_wr    = wr;
    io_rd    = rd;
    Address  = addr;
    D_In     = din;
    intr_ack = ack;
    w = int'(addr) >> 2;
    @(negedge clk);
    dout_s = D_Out;
    if (cs && rd && !wr) begin
      if (mem_m.exists(w)) check("read", dout_s, mem_m[w]);
    end else begin
      check("hiz", dout_s, 32'hzzzzzzzz);
    end
    @(posedge clk);
    m_edge++;
    reload = cs && wr && (w == TMR_WORD);
    fire   = m_armed && (m_edge == m_due) && !reload;
    nxt    = m_intr;
    if (fire) nxt = 1'b1;
    if (m_intr && ack) nxt = 1'b0;
    m_intr = nxt;
    if (reload) begin
      m_armed = (din[15:0] != 16'd0);
      m_due   = m_edge + int'(din[15:0]);
    end else if (fire) begin
      m_armed = 1'b0;
    end
    if (cs && wr) mem_m[w] = din;
    #1;
    check("intr", {31'b0, io_intr}, {31'b0, m_intr});
    $display("edge=%0d cs=%0b wr=%0b rd=%0b addr=%h din=%h dout=%h ack=%0b intr=%0b",
             m_edge, cs, wr, rd, addr, din, dout_s, ack, io_intr);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, ack);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    io_cs    = 1'b0;
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    intr_ack = 1'b0;
    rst      = 1'b0;
    #1;
    check("rst_intr", {31'b0, io_intr}, 32'd0);
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  logic [ADDR_W-1:0] pool [6];

  initial begin
    pool[0] = 12'h010; pool[1] = 12'h020; pool[2] = 12'h7F0;
    pool[3] = 12'hFFC; pool[4] = 12'h000; pool[5] = 12'hFF8;

    @(posedge clk);
    #1;
    do_reset();

    // Write/read, unaligned read, deselect, write-over-read.
    cycle(1, 1, 0, 12'h010, 32'hDEADBEEF, 0);
    cycle(1, 0, 1, 12'h010, 32'h0, 0);
    cycle(1, 0, 1, 12'h013, 32'h0, 0);
    cycle(0, 0, 1, 12'h010, 32'h0, 0);
    cycle(1, 1, 1, 12'h010, 32'h12345678, 0);
    cycle(1, 0, 1, 12'h010, 32'h0, 0);

    // Power-on interrupt at edge 20, held while unacknowledged, then acked.
    idle(24, 0);
    cycle(0, 0, 0, '0, '0, 1);
    idle(2, 0);

    // Rearm with 5, read back the reload word, then disarm with 0.
    cycle(1, 1, 0, 12'hFFC, 32'h00000005, 0);
    idle(6, 0);
    cycle(1, 0, 1, 12'hFFC, 32'h0, 0);
    cycle(0, 0, 0, '0, '0, 1);
    cycle(1, 1, 0, 12'hFFC, 32'h00000000, 0);
    idle(30, 0);

    // Asynchronous reset while the interrupt is up; memory must survive.
    cycle(1, 1, 0, 12'hFFC, 32'h00000003, 0);
    idle(4, 0);
    do_reset();
    cycle(1, 0, 1, 12'h010, 32'h0, 0);

    // Acknowledge held from reset release is ignored until io_intr rises.
    do_reset();
    idle(25, 1);

    // Simultaneous acknowledge and reload.
    cycle(1, 1, 0, 12'hFFC, 32'h00000002, 0);
    idle(3, 0);
    cycle(1, 1, 0, 12'hFFC, 32'h00000007, 1);
    idle(9, 0);

    // Randomized traffic mixing memory accesses, reloads and acknowledges.
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
      bit                cs;
      bit                wr;
      bit                rd;
      bit                ack;
      a   = pool[$urandom_range(0, 5)] | ADDR_W'($urandom_range(0, 3));
      d   = ((a >> 2) == ADDR_W'(TMR_WORD)) ? 32'($urandom_range(0, 12)) : $urandom;
      cs  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 1) == 0);
      ack = ($urandom_range(0, 7) == 0);
      cycle(cs, wr, rd, a, d, ack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
